// File: rtl/periph_pkg.sv
// Shared definitions for the APB machine-timer: register offsets, responder states,
// control-register layout and the byte-strobe merge helper.
package periph_pkg;

   localparam int unsigned APB_AW  = 32;
   localparam int unsigned APB_DW  = 32;
   localparam int unsigned STRB_W  = APB_DW / 8;
   localparam int unsigned MTIME_W = 64;
   localparam int unsigned DIV_W   = 8;
   localparam int unsigned WCNT_W  = 2;

   localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] OFF_CTRL        = 5'h10;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic             en;
   } ctrl_t;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [APB_DW-1:0] strb_merge(input logic [APB_DW-1:0] old_v,
                                                    input logic [APB_DW-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
      logic [APB_DW-1:0] r;
      r = old_v;
      for (int i = 0; i < int'(STRB_W); i++) begin
         if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator for the machine timer: counts 0..div while enabled and pulses tick
// on the terminal count.
module mtimer_prescaler
   import periph_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             clear,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // A divider rewrite restarts the count so the new period begins cleanly.
   always_comb begin
      tick  = en && (cnt_q == div);
      cnt_d = cnt_q;
      if (clear)   cnt_d = '0;
      else if (en) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
   end

endmodule

// File: rtl/apb_mtimer.sv
// APB-attached 64-bit machine timer with compare interrupt, prescaler and
// configurable access-phase wait states.
module apb_mtimer
   import periph_pkg::*;
#(
   parameter int unsigned      WAIT_STATES = 1,
   parameter logic [DIV_W-1:0] RESET_DIV   = 8'd0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                psel,
   input  logic                penable,
   input  logic [APB_AW-1:0]   paddr,
   input  logic                pwrite,
   input  logic [APB_DW-1:0]   pwdata,
   input  logic [STRB_W-1:0]   pwstrb,
   output logic                pready,
   output logic [APB_DW-1:0]   prdata,
   output logic                pslverr,
   output logic [MTIME_W-1:0]  mtime,
   output logic                mtimer_int
);

   apb_state_e          state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [MTIME_W-1:0]  mtime_q, mtime_d, mtime_inc;
   logic [MTIME_W-1:0]  mtimecmp_q, mtimecmp_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic                int_q, int_d;

   logic                addr_err;
   logic                wr_en;
   logic                div_clear;
   logic                tick;
   logic [APB_DW-1:0]   rdata_c;
   logic                unused_addr;

   assign unused_addr = ^paddr[APB_AW-1:5];

   // Responder FSM state and wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wcnt_d = '0;
            if (psel && !penable) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_d = ST_IDLE;
               wcnt_d  = '0;
            end else if (penable && (wcnt_q == WCNT_W'(WAIT_STATES))) begin
               pready  = 1'b1;
               state_d = ST_IDLE;
               wcnt_d  = '0;
            end else if (penable && (wcnt_q < WCNT_W'(WAIT_STATES))) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   assign addr_err  = (paddr[1:0] != 2'b00) || (paddr[4:0] > OFF_CTRL);
   assign wr_en     = pready && pwrite && !addr_err;
   assign div_clear = wr_en && (paddr[4:0] == OFF_CTRL) && pwstrb[1];

   mtimer_prescaler u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .en    (ctrl_q.en),
      .div   (ctrl_q.div),
      .clear (div_clear),
      .tick  (tick)
   );

   // Register read mux; error responses return zero
   always_comb begin
      rdata_c = '0;
      case (paddr[4:0])
         OFF_MTIME_LO:    rdata_c = mtime_q[31:0];
         OFF_MTIME_HI:    rdata_c = mtime_q[63:32];
         OFF_MTIMECMP_LO: rdata_c = mtimecmp_q[31:0];
         OFF_MTIMECMP_HI: rdata_c = mtimecmp_q[63:32];
         OFF_CTRL:        rdata_c = {16'h0000, ctrl_q.div, 7'b0000000, ctrl_q.en};
         default:         rdata_c = '0;
      endcase
   end

   assign prdata  = (pready && !addr_err) ? rdata_c : '0;
   assign pslverr = pready && addr_err;

   // Register next-state: the increment lands first so a same-cycle write overrides only its bytes
   always_comb begin
      mtime_inc  = mtime_q + MTIME_W'(tick);
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      ctrl_d     = ctrl_q;
      int_d      = (mtime_q >= mtimecmp_q);
      if (wr_en) begin
         case (paddr[4:0])
            OFF_MTIME_LO:    mtime_d[31:0]     = strb_merge(mtime_inc[31:0], pwdata, pwstrb);
            OFF_MTIME_HI:    mtime_d[63:32]    = strb_merge(mtime_inc[63:32], pwdata, pwstrb);
            OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = strb_merge(mtimecmp_q[31:0], pwdata, pwstrb);
            OFF_MTIMECMP_HI: mtimecmp_d[63:32] = strb_merge(mtimecmp_q[63:32], pwdata, pwstrb);
            OFF_CTRL: begin
               if (pwstrb[0]) ctrl_d.en  = pwdata[0];
               if (pwstrb[1]) ctrl_d.div = pwdata[15:8];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ctrl_q     <= '{div: RESET_DIV, en: 1'b1};
         int_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ctrl_q     <= ctrl_d;
         int_q      <= int_d;
      end
   end

   assign mtime      = mtime_q;
   assign mtimer_int = int_q;

endmodule

// File: tb/tb_apb_mtimer.sv
// Directed self-checking bench for apb_mtimer (WAIT_STATES=1, RESET_DIV=0).
module tb_apb_mtimer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic [31:0] paddr = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pwstrb = '0;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic [63:0] mtime;
   logic        mtimer_int;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rd;
   logic        err;
   int          cyc;

   apb_mtimer #(.WAIT_STATES(1), .RESET_DIV(8'd0)) dut (
      .clk        (clk),
      .rst        (rst),
      .psel       (psel),
      .penable    (penable),
      .paddr      (paddr),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .pwstrb     (pwstrb),
      .pready     (pready),
      .prdata     (prdata),
      .pslverr    (pslverr),
      .mtime      (mtime),
      .mtimer_int (mtimer_int)
   );

   always #5 clk = ~clk;

   // One APB transfer starting at the current negedge; returns at the negedge after completion.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic rerr,
                       output int ncyc);
      logic got;
      got = 1'b0; rdata = '0; rerr = 1'b0; ncyc = 0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pwstrb = strb;
      @(negedge clk);
      penable = 1'b1;
      while (!got && ncyc < 8) begin
         ncyc++;
         if (pready === 1'b1) begin
            got = 1'b1; rdata = prdata; rerr = pslverr;
         end
         @(negedge clk);
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwstrb = '0;
      if (!got) begin
         n_checks++;
         $display("FAIL xfer_timeout addr=%h: pready never rose", addr);
      end
   endtask

   task automatic wr32(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] d;
      logic e;
      int c;
      xfer(1'b1, addr, data, strb, d, e, c);
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_checks++; if (pready !== 1'b0) $display("FAIL rst_pready got %b exp 0", pready); else n_pass++;
      n_checks++; if (pslverr !== 1'b0) $display("FAIL rst_pslverr got %b exp 0", pslverr); else n_pass++;
      n_checks++; if (prdata !== 32'h0) $display("FAIL rst_prdata got %h exp 0", prdata); else n_pass++;
      n_checks++; if (mtime !== 64'h0) $display("FAIL rst_mtime got %h exp 0", mtime); else n_pass++;
      n_checks++; if (mtimer_int !== 1'b0) $display("FAIL rst_int got %b exp 0", mtimer_int); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_lo got %h exp ffffffff", rd); else n_pass++;
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_hi got %h exp ffffffff", rd); else n_pass++;
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'h0000_0001) $display("FAIL rst_ctrl got %h exp 00000001", rd); else n_pass++;
   endtask

   task automatic test_write_latency();
      xfer(1'b1, 32'h08, 32'h0000_0010, 4'hF, rd, err, cyc);
      n_checks++; if (cyc !== 2) $display("FAIL wr_latency got %0d exp 2", cyc); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL wr_pslverr got %b exp 0", err); else n_pass++;
      xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'h0000_0010) $display("FAIL cmp_lo_readback got %h exp 00000010", rd); else n_pass++;
      n_checks++; if (cyc !== 2) $display("FAIL rd_latency got %0d exp 2", cyc); else n_pass++;
   endtask

   task automatic test_error();
      xfer(1'b0, 32'h14, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (err !== 1'b1) $display("FAIL err14_pslverr got %b exp 1", err); else n_pass++;
      n_checks++; if (rd !== 32'h0) $display("FAIL err14_prdata got %h exp 0", rd); else n_pass++;
      xfer(1'b1, 32'h09, 32'hDEAD_BEEF, 4'hF, rd, err, cyc);
      n_checks++; if (err !== 1'b1) $display("FAIL err_unaligned got %b exp 1", err); else n_pass++;
      xfer(1'b1, 32'h18, 32'hDEAD_BEEF, 4'hF, rd, err, cyc);
      n_checks++; if (err !== 1'b1) $display("FAIL err18 got %b exp 1", err); else n_pass++;
      xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'h0000_0010) $display("FAIL err_no_side_effect got %h exp 00000010", rd); else n_pass++;
   endtask

   task automatic test_abort();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h77; pwstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      n_checks++; if (pready !== 1'b0) $display("FAIL abort_pready got %b exp 0", pready); else n_pass++;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'h0000_0010) $display("FAIL abort_no_write got %h exp 00000010", rd); else n_pass++;
   endtask

   task automatic test_prescaler();
      wr32(32'h10, 32'h0000_0300, 4'h3);
      wr32(32'h00, 32'h0, 4'hF);
      wr32(32'h04, 32'h0, 4'hF);
      wr32(32'h10, 32'h0000_0301, 4'h3);
      n_checks++; if (mtime !== 64'h0) $display("FAIL psc_start got %h exp 0", mtime); else n_pass++;
      repeat (19) @(negedge clk);
      n_checks++; if (mtime !== 64'h4) $display("FAIL psc_19 got %h exp 4", mtime); else n_pass++;
      @(negedge clk);
      n_checks++; if (mtime !== 64'h5) $display("FAIL psc_20 got %h exp 5", mtime); else n_pass++;
   endtask

   task automatic test_wrap();
      wr32(32'h10, 32'h0, 4'h3);
      wr32(32'h00, 32'hFFFF_FFFF, 4'hF);
      wr32(32'h04, 32'h0, 4'hF);
      wr32(32'h10, 32'h1, 4'h3);
      n_checks++; if (mtime !== 64'h0000_0000_FFFF_FFFF) $display("FAIL carry_pre got %h exp 00000000ffffffff", mtime); else n_pass++;
      @(negedge clk);
      n_checks++; if (mtime !== 64'h0000_0001_0000_0000) $display("FAIL carry got %h exp 0000000100000000", mtime); else n_pass++;
      wr32(32'h10, 32'h0, 4'h3);
      wr32(32'h00, 32'hFFFF_FFFF, 4'hF);
      wr32(32'h04, 32'hFFFF_FFFF, 4'hF);
      wr32(32'h10, 32'h1, 4'h3);
      n_checks++; if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_pre got %h exp all ones", mtime); else n_pass++;
      @(negedge clk);
      n_checks++; if (mtime !== 64'h0) $display("FAIL wrap got %h exp 0", mtime); else n_pass++;
   endtask

   task automatic test_interrupt();
      wr32(32'h10, 32'h0, 4'h3);
      wr32(32'h00, 32'h0000_001E, 4'hF);
      wr32(32'h04, 32'h0, 4'hF);
      wr32(32'h08, 32'h0000_0020, 4'hF);
      wr32(32'h0C, 32'h0, 4'hF);
      wr32(32'h10, 32'h1, 4'h3);
      n_checks++; if (mtime !== 64'h1E || mtimer_int !== 1'b0) $display("FAIL int_t0 mtime %h int %b exp 1e/0", mtime, mtimer_int); else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++; if (mtime !== 64'h20 || mtimer_int !== 1'b0) $display("FAIL int_at_eq mtime %h int %b exp 20/0", mtime, mtimer_int); else n_pass++;
      @(negedge clk);
      n_checks++; if (mtimer_int !== 1'b1) $display("FAIL int_rise got %b exp 1", mtimer_int); else n_pass++;
      wr32(32'h0C, 32'hFFFF_FFFF, 4'hF);
      n_checks++; if (mtimer_int !== 1'b1) $display("FAIL int_hold got %b exp 1", mtimer_int); else n_pass++;
      @(negedge clk);
      n_checks++; if (mtimer_int !== 1'b0) $display("FAIL int_fall got %b exp 0", mtimer_int); else n_pass++;
   endtask

   task automatic test_strobe();
      wr32(32'h10, 32'hAABB_CCDD, 4'b0010);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'h0000_CC01) $display("FAIL ctrl_strb got %h exp 0000cc01", rd); else n_pass++;
   endtask

   task automatic test_back_to_back();
      wr32(32'h10, 32'h0, 4'h3);
      wr32(32'h00, 32'hFFFF_FFFD, 4'hF);
      wr32(32'h04, 32'h0, 4'hF);
      wr32(32'h10, 32'h1, 4'h3);
      wr32(32'h00, 32'h0000_0055, 4'b0001);
      n_checks++; if (mtime !== 64'h0000_0001_0000_0055) $display("FAIL tick_and_write got %h exp 0000000100000055", mtime); else n_pass++;
   endtask

   task automatic test_reset_mid();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0000_0500; pwstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      rst = 1'b1;
      #1;
      n_checks++; if (pready !== 1'b0) $display("FAIL rstmid_pready got %b exp 0", pready); else n_pass++;
      n_checks++; if (mtime !== 64'h0) $display("FAIL rstmid_mtime got %h exp 0", mtime); else n_pass++;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
      @(negedge clk);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'h0000_0001) $display("FAIL rstmid_ctrl got %h exp 00000001", rd); else n_pass++;
      xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rstmid_cmp_hi got %h exp ffffffff", rd); else n_pass++;
      xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc);
      n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rstmid_cmp_lo got %h exp ffffffff", rd); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_latency();
      test_error();
      test_abort();
      test_prescaler();
      test_wrap();
      test_interrupt();
      test_strobe();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
